// File: rtl/count_sequencer_if.sv
// count_sequencer_if: configuration handshake, run control and status bundle for count_sequencer.
// Ports (master drives / slave drives):
//   master -> slave : cfg_valid, cfg_term[W], cfg_mode, start, stop, pause
//   slave -> master : cfg_ready, count[W], busy, tc_pulse, done, wrap_cnt[WRAP_W]
interface count_sequencer_if #(
    parameter int W      = 6,
    parameter int WRAP_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [W-1:0]      cfg_term;
    logic              cfg_mode;
    logic              start;
    logic              stop;
    logic              pause;
    logic [W-1:0]      count;
    logic              busy;
    logic              tc_pulse;
    logic              done;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output cfg_valid, cfg_term, cfg_mode, start, stop, pause,
        input  cfg_ready, count, busy, tc_pulse, done, wrap_cnt
    );

    modport slave (
        input  cfg_valid, cfg_term, cfg_mode, start, stop, pause,
        output cfg_ready, count, busy, tc_pulse, done, wrap_cnt
    );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: sequences a W-bit event counter through IDLE/RUN/DONE with one-shot or periodic reload.
// Ports:
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : count_sequencer_if.slave (cfg handshake, start/stop/pause, count/busy/tc_pulse/done/wrap_cnt)
module count_sequencer #(
    parameter int W      = 6,
    parameter int WRAP_W = 8
) (
    input logic               clk,
    input logic               clr_n,
    count_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      count_q, count_d;
    logic [W-1:0]      term_q, term_d;
    logic              mode_q, mode_d;
    logic              tc_q, tc_d;
    logic              done_q, done_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              cfg_ok;

    assign bus.cfg_ready = state_q != RUN;
    assign bus.busy      = state_q == RUN;
    assign bus.count     = count_q;
    assign bus.tc_pulse  = tc_q;
    assign bus.done      = done_q;
    assign bus.wrap_cnt  = wrap_q;
    assign cfg_ok        = bus.cfg_valid && state_q != RUN;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= '1;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Config is only taken outside RUN, so the compare below always sees the
    // terminal count the current run was started with.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = cfg_ok ? bus.cfg_term : term_q;
        mode_d  = cfg_ok ? bus.cfg_mode : mode_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        wrap_d  = wrap_q;
        if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (state_q != RUN) begin
            if (bus.start) begin
                state_d = RUN;
                count_d = '0;
                done_d  = 1'b0;
                wrap_d  = '0;
            end
        end else if (!bus.pause) begin
            if (count_q == term_q) begin
                count_d = '0;
                tc_d    = 1'b1;
                wrap_d  = &wrap_q ? wrap_q : wrap_q + 1'b1;
                state_d = mode_q ? RUN : DONE;
                done_d  = !mode_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scoreboard bench for count_sequencer.
// Each step drives inputs, pushes the reference model's expected outputs, then pops and compares after the edge.
module tb_count_sequencer;
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

    typedef struct packed {
        logic [5:0] count;
        logic       tc;
        logic       busy;
        logic       done;
        logic [7:0] wrap;
        logic       rdy;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t  q[$];
    string tq[$];

    int         m_state;
    logic [5:0] m_count, m_term;
    logic       m_mode, m_tc, m_done;
    logic [7:0] m_wrap;

    count_sequencer_if #(.W(6), .WRAP_W(8)) bus();
    count_sequencer #(.W(6), .WRAP_W(8)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_count = '0;
        m_term  = 6'd63;
        m_mode  = 1'b0;
        m_tc    = 1'b0;
        m_done  = 1'b0;
        m_wrap  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"}, bus.count, 0);
        chk({tag, ".tc"}, bus.tc_pulse, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".wrap"}, bus.wrap_cnt, 0);
        chk({tag, ".rdy"}, bus.cfg_ready, 1);
    endtask

    task automatic step(input string tag, input logic cv, input logic [5:0] ct, input logic cm,
                        input logic st, input logic sp, input logic pa);
        exp_t  e;
        string t;
        logic  rdy;
        bus.cfg_valid = cv;
        bus.cfg_term  = ct;
        bus.cfg_mode  = cm;
        bus.start     = st;
        bus.stop      = sp;
        bus.pause     = pa;
        rdy  = m_state != S_RUN;
        m_tc = 1'b0;
        if (cv && rdy) begin
            m_term = ct;
            m_mode = cm;
        end
        if (sp) begin
            m_state = S_IDLE;
            m_count = '0;
            m_done  = 1'b0;
        end else if (rdy) begin
            if (st) begin
                m_state = S_RUN;
                m_count = '0;
                m_done  = 1'b0;
                m_wrap  = '0;
            end
        end else if (!pa) begin
            if (m_count == m_term) begin
                m_count = '0;
                m_tc    = 1'b1;
                if (m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
                if (!m_mode) begin
                    m_state = S_DONE;
                    m_done  = 1'b1;
                end
            end else begin
                m_count = m_count + 6'd1;
            end
        end
        e.count = m_count;
        e.tc    = m_tc;
        e.busy  = m_state == S_RUN;
        e.done  = m_done;
        e.wrap  = m_wrap;
        e.rdy   = m_state != S_RUN;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        e = q.pop_front();
        t = tq.pop_front();
        chk({t, ".count"}, bus.count, e.count);
        chk({t, ".tc"}, bus.tc_pulse, e.tc);
        chk({t, ".busy"}, bus.busy, e.busy);
        chk({t, ".done"}, bus.done, e.done);
        chk({t, ".wrap"}, bus.wrap_cnt, e.wrap);
        chk({t, ".rdy"}, bus.cfg_ready, e.rdy);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pulses;
        bus.cfg_valid = 0;
        bus.cfg_term  = 0;
        bus.cfg_mode  = 0;
        bus.start     = 0;
        bus.stop      = 0;
        bus.pause     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        clr_n = 1'b1;

        // one-shot T=5
        step("t1_start", 1, 6'd5, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) idle("t1_run");
        chk("t1_end.tc", bus.tc_pulse, 1);
        chk("t1_end.done", bus.done, 1);
        chk("t1_end.busy", bus.busy, 0);
        chk("t1_end.wrap", bus.wrap_cnt, 1);
        idle("t1_after");

        // periodic T=3 for 12 counting cycles
        step("t2_start", 1, 6'd3, 1, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            idle("t2_run");
            pulses += int'(bus.tc_pulse);
        end
        chk("t2_pulses", pulses, 3);
        chk("t2_wrap", bus.wrap_cnt, 3);
        chk("t2_busy", bus.busy, 1);
        step("t2_stop", 0, 0, 0, 0, 1, 0);

        // periodic T=2 with pause held at the terminal count
        step("t3_start", 1, 6'd2, 1, 1, 0, 0);
        idle("t3_run");
        idle("t3_run");
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step("t3_pause", 0, 0, 0, 0, 0, 1);
            pulses += int'(bus.tc_pulse);
        end
        chk("t3_pause_pulses", pulses, 0);
        chk("t3_pause_count", bus.count, 2);
        idle("t3_resume");
        chk("t3_resume_tc", bus.tc_pulse, 1);

        // stop and start together at count == term
        idle("t4_run");
        idle("t4_run");
        step("t4_stop_start", 0, 0, 0, 1, 1, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_tc", bus.tc_pulse, 0);
        chk("t4_count", bus.count, 0);

        // config offered during RUN is ignored, then taken in DONE with start
        step("t5_start", 1, 6'd3, 0, 1, 0, 0);
        step("t5_cfg_in_run", 1, 6'd10, 0, 0, 0, 0);
        chk("t5_rdy_in_run", bus.cfg_ready, 0);
        for (int i = 0; i < 3; i++) step("t5_run", 1, 6'd10, 0, 0, 0, 0);
        chk("t5_done_old_t", bus.done, 1);
        step("t5_restart", 1, 6'd10, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) idle("t5_run10");
        chk("t5_count10", bus.count, 10);
        idle("t5_fire10");
        chk("t5_done_new_t", bus.done, 1);

        // asynchronous reset mid-run
        step("t6_start", 1, 6'd8, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) idle("t6_run");
        chk("t6_count4", bus.count, 4);
        #2 clr_n = 1'b0;
        #1 check_reset_outputs("t6_async_reset");
        #1 clr_n = 1'b1;
        model_reset();
        step("t6_default_start", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 63; i++) idle("t6_run63");
        chk("t6_count63", bus.count, 63);
        idle("t6_fire63");
        chk("t6_done63", bus.done, 1);

        // periodic T=0: pulse every cycle, wrap_cnt saturates
        step("t7_start", 1, 6'd0, 1, 1, 0, 0);
        for (int i = 0; i < 260; i++) idle("t7_run");
        chk("t7_wrap_sat", bus.wrap_cnt, 255);
        chk("t7_tc", bus.tc_pulse, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
